// File: rtl/fetch_unit.sv
// Instruction fetch front end: ROM request pipeline feeding a 2-entry
// {instruction, pc} buffer toward decode, with redirect flush.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'h0001
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] rom_address,
    input  logic [15:0] rom_q,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_target,
    input  logic        decode_ready,
    output logic        instr_valid,
    output logic [15:0] instr_out,
    output logic [15:0] instr_pc,
    output logic [1:0]  occupancy
);

    logic [15:0] r_pc;
    logic        r_infl;
    logic [15:0] r_infl_pc;
    logic [15:0] r_instr [2];
    logic [15:0] r_ipc   [2];
    logic        r_head;
    logic [1:0]  r_cnt;

    logic        w_pop;
    logic        w_push;
    logic        w_fire;
    logic        w_wr;
    logic [1:0]  w_pending;

    assign occupancy   = r_cnt;
    assign instr_valid = !reset && (r_cnt != 2'd0) && !redirect_valid;
    assign instr_out   = r_instr[r_head];
    assign instr_pc    = r_ipc[r_head];
    assign rom_address = reset          ? RESET_PC :
                         redirect_valid ? redirect_target : r_pc;

    assign w_pop     = instr_valid && decode_ready;
    assign w_push    = r_infl && !redirect_valid;
    assign w_pending = r_cnt + {1'b0, r_infl};
    // Requests are throttled so buffered plus in-flight words never exceed 2.
    assign w_fire    = redirect_valid || (w_pending < 2'd2) || w_pop;
    assign w_wr      = r_head ^ r_cnt[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_infl    <= 1'b0;
            r_infl_pc <= RESET_PC;
            r_head    <= 1'b0;
            r_cnt     <= 2'd0;
        end else begin
            r_infl <= w_fire;
            if (w_fire) begin
                r_infl_pc <= rom_address;
                r_pc      <= rom_address + PC_STEP;
            end else if (redirect_valid) begin
                r_pc <= redirect_target;
            end
            if (redirect_valid) begin
                r_cnt  <= 2'd0;
                r_head <= 1'b0;
            end else begin
                r_cnt  <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
                r_head <= r_head ^ w_pop;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[w_wr] <= rom_q;
            r_ipc[w_wr]   <= r_infl_pc;
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (reset)
        !(w_push && !w_pop && r_cnt == 2'd2)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM model word[i] = i + 16'h1000,
// issued-instruction scoreboard plus per-cycle point checks.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] rom_address;
    logic [15:0] rom_q;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic        decode_ready;
    logic        instr_valid;
    logic [15:0] instr_out;
    logic [15:0] instr_pc;
    logic [1:0]  occupancy;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom_address + 16'h1000;

    fetch_unit #(.RESET_PC(16'h0000), .PC_STEP(16'h0001)) dut (
        .clk             (clk),
        .reset           (reset),
        .rom_address     (rom_address),
        .rom_q           (rom_q),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .decode_ready    (decode_ready),
        .instr_valid     (instr_valid),
        .instr_out       (instr_out),
        .instr_pc        (instr_pc),
        .occupancy       (occupancy)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Set this cycle's inputs, then move to the sampling point.
    task automatic drive(input logic rst, input logic rv,
                         input logic [15:0] tgt, input logic rdy);
        reset           = rst;
        redirect_valid  = rv;
        redirect_target = tgt;
        decode_ready    = rdy;
        @(negedge clk);
    endtask

    // Scoreboard every issued instruction, then step past the edge.
    task automatic adv();
        logic [15:0] e;
        if (instr_valid && decode_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_issue", instr_pc, 16'hxxxx);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", instr_pc, e);
                chk("sb_instr", instr_out, e + 16'h1000);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_target = 16'h0000;
        decode_ready = 1'b0;
        @(posedge clk);
        #1;
        // reset cycle, redirect and ready asserted but dominated
        drive(1'b1, 1'b1, 16'h0300, 1'b1);
        chk("rst_occ", {14'd0, occupancy}, 16'd0);
        chk("rst_valid", {15'd0, instr_valid}, 16'd0);
        chk("rst_addr", rom_address, 16'h0000);
        adv();

        for (int i = 0; i < 6; i++) exp_q.push_back(16'(i));
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("c0_valid", {15'd0, instr_valid}, 16'd0);
        chk("c0_addr", rom_address, 16'h0000);
        adv();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("c1_valid", {15'd0, instr_valid}, 16'd0);
        adv();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("c2_valid", {15'd0, instr_valid}, 16'd1);
        chk("c2_pc", instr_pc, 16'h0000);
        adv();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        adv();

        // decode stall: buffer fills to 2, address frozen
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        chk("c4_occ", {14'd0, occupancy}, 16'd1);
        adv();
        for (int c = 5; c < 10; c++) begin
            drive(1'b0, 1'b0, 16'h0, 1'b0);
            chk("stall_occ", {14'd0, occupancy}, 16'd2);
            chk("stall_addr", rom_address, 16'h0004);
            chk("stall_pc", instr_pc, 16'h0002);
            adv();
        end
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("c10_pc", instr_pc, 16'h0002);
        adv();
        for (int c = 11; c < 14; c++) begin
            drive(1'b0, 1'b0, 16'h0, 1'b1);
            adv();
        end

        // redirect to 0x0040
        exp_q.push_back(16'h0040);
        exp_q.push_back(16'h0041);
        drive(1'b0, 1'b1, 16'h0040, 1'b1);
        chk("c14_valid", {15'd0, instr_valid}, 16'd0);
        chk("c14_addr", rom_address, 16'h0040);
        adv();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("c15_valid", {15'd0, instr_valid}, 16'd0);
        chk("c15_occ", {14'd0, occupancy}, 16'd0);
        adv();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("c16_valid", {15'd0, instr_valid}, 16'd1);
        chk("c16_pc", instr_pc, 16'h0040);
        chk("c16_instr", instr_out, 16'h1040);
        adv();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        adv();

        // redirect to 0xFFFF, PC wraps
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0001);
        drive(1'b0, 1'b1, 16'hFFFF, 1'b1);
        adv();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("c19_valid", {15'd0, instr_valid}, 16'd0);
        adv();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("c20_pc", instr_pc, 16'hFFFF);
        adv();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("c21_pc", instr_pc, 16'h0000);
        adv();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("c22_pc", instr_pc, 16'h0001);
        adv();
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        adv();
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        chk("c24_occ", {14'd0, occupancy}, 16'd2);
        adv();

        // redirect with full buffer and ready high: flush, no pop
        exp_q.push_back(16'h0100);
        drive(1'b0, 1'b1, 16'h0100, 1'b1);
        chk("c25_valid", {15'd0, instr_valid}, 16'd0);
        chk("c25_addr", rom_address, 16'h0100);
        adv();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("c26_occ", {14'd0, occupancy}, 16'd0);
        chk("c26_valid", {15'd0, instr_valid}, 16'd0);
        adv();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("c27_pc", instr_pc, 16'h0100);
        adv();
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        adv();

        // mid-run reset with a full buffer
        drive(1'b1, 1'b1, 16'h0300, 1'b1);
        chk("c29_occ_before", {14'd0, occupancy}, 16'd2);
        chk("c29_valid", {15'd0, instr_valid}, 16'd0);
        chk("c29_addr", rom_address, 16'h0000);
        adv();
        for (int i = 0; i < 3; i++) exp_q.push_back(16'(i));
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("c30_occ", {14'd0, occupancy}, 16'd0);
        chk("c30_valid", {15'd0, instr_valid}, 16'd0);
        chk("c30_addr", rom_address, 16'h0000);
        adv();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        adv();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        chk("c32_pc", instr_pc, 16'h0000);
        adv();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        adv();
        drive(1'b0, 1'b0, 16'h0, 1'b1);
        adv();

        drive(1'b0, 1'b0, 16'h0, 1'b0);
        chk("sb_drained", 16'(exp_q.size()), 16'd0);
        adv();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
